// File: rtl/data_serializer.sv
// rtl/data_serializer.sv - 2:1 width-halving serializer with a 2-entry input buffer
module data_serializer #(
    parameter int DOUT_WIDTH = 128,
    parameter bit LOW_FIRST  = 1'b1
) (
    input  logic                    CLK,
    input  logic                    RESETN,
    input  logic                    iVALID,
    output logic                    oREADY,
    input  logic [2*DOUT_WIDTH-1:0] DIN,
    output logic                    oVALID,
    input  logic                    iREADY,
    output logic [DOUT_WIDTH-1:0]   DOUT,
    output logic                    oLAST
);

    logic [2*DOUT_WIDTH-1:0] mem [2];
    logic                    wr_ptr;
    logic                    rd_ptr;
    logic [1:0]              count;
    logic                    beat;

    logic                    push;
    logic                    xfer;
    logic                    pop;
    logic                    sel_high;
    logic [2*DOUT_WIDTH-1:0] head;

    // oREADY is gated by RESETN so it drops the moment reset asserts,
    // and otherwise depends only on the registered fill level.
    assign oREADY   = RESETN & (count != 2'd2);
    assign oVALID   = (count != 2'd0);
    assign oLAST    = oVALID & beat;

    assign push     = iVALID & oREADY;
    assign xfer     = oVALID & iREADY;
    assign pop      = xfer & beat;

    // Beat 0 is the low half when LOW_FIRST is set, the high half otherwise.
    assign sel_high = LOW_FIRST ? beat : ~beat;
    assign head     = mem[rd_ptr];

    // Output mux: head-entry half, or all ones while nothing is buffered.
    always_comb begin
        DOUT = '1;
        if (oVALID) begin
            DOUT = sel_high ? head[2*DOUT_WIDTH-1:DOUT_WIDTH] : head[DOUT_WIDTH-1:0];
        end
    end

    // Buffer storage; contents need no reset since count gates visibility.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr_ptr] <= DIN;
        end
    end

    // Pointers, fill level and beat index; reset drops any partial word.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
            beat   <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (xfer) begin
                beat <= ~beat;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_data_serializer.sv
// tb/tb_data_serializer.sv - scoreboard bench for data_serializer
module tb_data_serializer;

    localparam int W  = 128;
    localparam int W2 = 16;

    typedef struct {
        logic [W-1:0] data;
        logic         last;
    } beat_t;

    logic           CLK;
    logic           RESETN;
    logic           iVALID;
    logic           oREADY;
    logic [2*W-1:0] DIN;
    logic           oVALID;
    logic           iREADY;
    logic [W-1:0]   DOUT;
    logic           oLAST;

    logic            v2;
    logic            rdy2;
    logic [2*W2-1:0] d2;
    logic            ov2;
    logic            r2;
    logic [W2-1:0]   dout2;
    logic            last2;

    int compared = 0;
    int mismatched = 0;
    int cyc = 0;
    int occ = 0;
    int xfer_cnt = 0;
    int last_xfer_cyc = 0;
    int mode = 0;
    beat_t q[$];

    data_serializer #(.DOUT_WIDTH(W), .LOW_FIRST(1'b1)) dut (
        .CLK(CLK), .RESETN(RESETN), .iVALID(iVALID), .oREADY(oREADY), .DIN(DIN),
        .oVALID(oVALID), .iREADY(iREADY), .DOUT(DOUT), .oLAST(oLAST)
    );

    data_serializer #(.DOUT_WIDTH(W2), .LOW_FIRST(1'b0)) dut_hi (
        .CLK(CLK), .RESETN(RESETN), .iVALID(v2), .oREADY(rdy2), .DIN(d2),
        .oVALID(ov2), .iREADY(r2), .DOUT(dout2), .oLAST(last2)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [2*W-1:0] rand_word();
        logic [2*W-1:0] w;
        for (int i = 0; i < 8; i++) w[i*32 +: 32] = $urandom;
        return w;
    endfunction

    // iREADY pattern generator: 0 high, 1 low, 2 toggle, 3 random, 4 manual
    initial begin
        iREADY = 1'b1;
        forever begin
            @(posedge CLK);
            #1;
            case (mode)
                0: iREADY = 1'b1;
                1: iREADY = 1'b0;
                2: iREADY = ~iREADY;
                3: iREADY = 1'($urandom_range(0, 1));
                default: ;
            endcase
        end
    end

    // Monitor: decisions made at the negedge describe the coming posedge.
    initial begin
        forever begin
            @(negedge CLK);
            if (RESETN) begin
                chk("oready_level", W'(oREADY), W'(occ != 2));
                chk("ovalid_level", W'(oVALID), W'(occ != 0));
                if (!oVALID) begin
                    chk("idle_dout", DOUT, '1);
                    chk("idle_olast", W'(oLAST), W'(0));
                end else if (q.size() == 0) begin
                    chk("beat_without_expectation", W'(oVALID), W'(0));
                end else begin
                    chk("dout", DOUT, q[0].data);
                    chk("olast", W'(oLAST), W'(q[0].last));
                end
                if (oVALID && iREADY && q.size() != 0) begin
                    if (q[0].last) occ--;
                    void'(q.pop_front());
                    xfer_cnt++;
                    last_xfer_cyc = cyc;
                end
                if (iVALID && oREADY) begin
                    q.push_back('{data: DIN[W-1:0],   last: 1'b0});
                    q.push_back('{data: DIN[2*W-1:W], last: 1'b1});
                    occ++;
                end
            end
        end
    end

    task automatic push_word(input logic [2*W-1:0] w);
        int n;
        iVALID = 1'b1;
        DIN    = w;
        n = 0;
        @(negedge CLK);
        while (!oREADY && n < 200) begin
            n++;
            @(negedge CLK);
        end
        if (n >= 200) chk("push_timeout", W'(oREADY), W'(1));
        @(posedge CLK);
        #1;
        iVALID = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q.size() != 0 || occ != 0) && n < 300) begin
            @(posedge CLK);
            n++;
        end
        #1;
        chk("drain_done", W'(q.size()), W'(0));
    endtask

    initial begin
        int t0;
        int start;
        int n;
        logic [2*W-1:0] w;
        RESETN = 1'b0;
        iVALID = 1'b0;
        DIN    = '0;
        v2     = 1'b0;
        d2     = '0;
        r2     = 1'b1;
        #2;
        chk("reset_ovalid", W'(oVALID), W'(0));
        chk("reset_oready", W'(oREADY), W'(0));
        chk("reset_olast", W'(oLAST), W'(0));
        chk("reset_dout", DOUT, '1);
        repeat (3) @(posedge CLK);
        #1;
        RESETN = 1'b1;
        @(posedge CLK);
        #1;

        // Directed word, upper = ...0001, lower = ...0002
        mode = 0;
        w = {128'h1, 128'h2};
        push_word(w);
        chk("first_beat_low", DOUT, 128'h2);
        drain();

        // LOW_FIRST=0 instance: upper half leaves first
        d2 = 32'hAAAA_BBBB;
        v2 = 1'b1;
        @(posedge CLK);
        #1;
        v2 = 1'b0;
        chk("hi_first_beat0", W'(dout2), W'(16'hAAAA));
        chk("hi_first_last0", W'(last2), W'(0));
        @(posedge CLK);
        #1;
        chk("hi_first_beat1", W'(dout2), W'(16'hBBBB));
        chk("hi_first_last1", W'(last2), W'(1));
        @(posedge CLK);
        #1;
        chk("hi_first_idle", W'({ov2, dout2}), W'({1'b0, 16'hFFFF}));

        // Streaming: 16 beats must occupy 16 consecutive cycles
        start = xfer_cnt;
        fork
            for (int i = 0; i < 8; i++) push_word(rand_word());
            begin
                n = 0;
                while (xfer_cnt < start + 1 && n < 300) begin @(posedge CLK); n++; end
                t0 = last_xfer_cyc;
                while (xfer_cnt < start + 16 && n < 300) begin @(posedge CLK); n++; end
                chk("stream_no_gaps", W'(last_xfer_cyc - t0), W'(15));
            end
        join
        drain();

        // Stall: third word held by the source until iREADY returns
        mode = 1;
        @(posedge CLK);
        #1;
        fork
            for (int i = 0; i < 3; i++) push_word(rand_word());
            begin
                repeat (8) @(posedge CLK);
                #1;
                chk("stall_full_oready", W'(oREADY), W'(0));
                chk("stall_queue_depth", W'(q.size()), W'(4));
                mode = 0;
            end
        join
        drain();

        // Reset mid-word with a second word buffered
        mode = 4;
        iREADY = 1'b0;
        push_word(rand_word());
        push_word(rand_word());
        iREADY = 1'b1;
        @(posedge CLK);
        #1;
        iREADY = 1'b0;
        chk("mid_word_olast", W'(oLAST), W'(1));
        #2;
        RESETN = 1'b0;
        #1;
        chk("async_reset_ovalid", W'(oVALID), W'(0));
        chk("async_reset_oready", W'(oREADY), W'(0));
        chk("async_reset_dout", DOUT, '1);
        q.delete();
        occ = 0;
        repeat (2) @(posedge CLK);
        #1;
        RESETN = 1'b1;
        mode = 0;
        repeat (4) @(posedge CLK);
        #1;
        chk("post_reset_idle", W'(oVALID), W'(0));
        w = rand_word();
        push_word(w);
        chk("post_reset_first_beat", DOUT, w[W-1:0]);
        drain();

        // Toggling iREADY with continuous pushes
        mode = 2;
        for (int i = 0; i < 12; i++) push_word(rand_word());
        drain();

        // Random ready and random source gaps
        mode = 3;
        for (int i = 0; i < 30; i++) begin
            push_word(rand_word());
            repeat ($urandom_range(0, 2)) @(posedge CLK);
            #1;
        end
        mode = 0;
        drain();

        repeat (3) @(posedge CLK);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
